// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU results win combinationally (0 latency), queued loads drain in order when the ALU is idle.
// Loads are backpressured via ld_ready once DEPTH entries are held; younger ALU writes squash queued loads to the same rd.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_wen,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_wdata,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_wdata,
    output logic                     wb_en,
    output logic [4:0]               wb_dir,
    output logic [XLEN-1:0]          wb_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_q   [DEPTH];
    logic [4:0]      rd_d   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pending_q, pending_d;

    logic alu_act, push, pop;

    always_comb begin
        alu_act  = alu_wen && (alu_rd != 5'd0);
        ld_ready = (count_q < CW'(DEPTH)) && rst;
        push     = ld_valid && ld_ready && (ld_rd != 5'd0);
        pop      = !alu_act && (count_q != '0);
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_dir  = 5'd0;
        wb_data = '0;
        if (alu_act) begin
            wb_en   = 1'b1;
            wb_dir  = alu_rd;
            wb_data = alu_wdata;
        end else if (pop && live_q[rptr_q]) begin
            wb_en   = 1'b1;
            wb_dir  = rd_q[rptr_q];
            wb_data = data_q[rptr_q];
        end
    end

    // Squash is applied before the enqueue so a same-cycle load stays live.
    always_comb begin
        rd_d      = rd_q;
        data_d    = data_q;
        live_d    = live_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        pending_d = '0;
        if (alu_act) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + 1'b1;
        end
        if (push) begin
            rd_d[wptr_q]   = ld_rd;
            data_d[wptr_q] = ld_wdata;
            live_d[wptr_q] = 1'b1;
            wptr_d         = wptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            if (live_d[i]) pending_d[rd_d[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            live_q    <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            live_q    <= live_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Payload needs no reset: live bits gate every use of it.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign pending    = pending_q;
    assign fifo_count = count_q;
endmodule
